// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue sitting between a word-addressed RAM with a
// one-cycle read latency and a CPU front end. The block keeps a fetch address
// (fpc), issues at most one read per cycle, captures the returning word one
// cycle later into a circular buffer, and presents the oldest entry to the CPU
// through a valid/ready handshake. A redirect from the CPU flushes everything,
// including a read still in flight, and restarts fetching at a new address.
//
// Parameters
//   DEPTH      number of queue entries (power of two, >= 2)
//   RESET_PC   first fetch address after reset
//   ADDR_STEP  address increment per fetched word
//
// Ports
//   clk             clock, all state changes on the rising edge
//   reset           synchronous active-high reset
//   ram_addr        RAM read address (always shows fpc)
//   ram_load        RAM read strobe, 1 = read issued this cycle
//   ram_data        RAM read data, valid the cycle after ram_load
//   redirect_valid  restart fetching at redirect_addr
//   redirect_addr   new fetch address
//   instr_valid     head entry valid
//   instr           head instruction word
//   instr_pc        address the head word was fetched from
//   instr_ready     CPU accepts the head entry
//   level           number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int unsigned ADDR_STEP = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic [31:0]               ram_addr,
   output logic                      ram_load,
   input  logic [31:0]               ram_data,
   input  logic                      redirect_valid,
   input  logic [31:0]               redirect_addr,
   output logic                      instr_valid,
   output logic [31:0]               instr,
   output logic [31:0]               instr_pc,
   input  logic                      instr_ready,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int          PW      = $clog2(DEPTH);
   localparam int          CW      = PW + 1;
   localparam logic [31:0] STEP    = 32'(ADDR_STEP);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   // Architectural state
   logic [31:0]   fpc_r;
   logic [31:0]   ipc_r;
   logic          inflight_r;
   logic [PW-1:0] rp_r;
   logic [PW-1:0] wp_r;
   logic [CW-1:0] count_r;

   // Entry storage (data only, no reset needed: count gates visibility)
   logic [31:0]   instr_mem_r [DEPTH];
   logic [31:0]   pc_mem_r    [DEPTH];

   // Per-cycle control
   logic          pop_s;
   logic          push_s;
   logic          issue_s;
   logic [CW:0]   occ_s;

   // Handshake, capture and issue decisions for the current cycle
   always_comb begin
      pop_s   = 1'b0;
      push_s  = 1'b0;
      issue_s = 1'b0;
      occ_s   = {1'b0, count_r};

      if (count_r != {CW{1'b0}}) begin
         pop_s = instr_ready;
      end else begin
         pop_s = 1'b0;
      end

      // A response is only kept if no flush (reset or redirect) hits this
      // cycle; a flushed in-flight read is thereby discarded.
      if (inflight_r && !redirect_valid && !reset) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end

      // Projected occupancy: entries held, plus the word about to land,
      // minus the one leaving. Issuing only below DEPTH guarantees the
      // capture next cycle always finds a free slot.
      occ_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};

      if (!reset && !redirect_valid && (occ_s < DEPTH_C)) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
   end

   // Control state: fetch address, in-flight tag, pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         fpc_r      <= RESET_PC;
         ipc_r      <= 32'h0;
         inflight_r <= 1'b0;
         rp_r       <= {PW{1'b0}};
         wp_r       <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
      end else if (redirect_valid) begin
         // Redirect wins over push and pop; back-to-back redirects simply
         // keep overwriting fpc, so the last address sticks.
         fpc_r      <= redirect_addr;
         inflight_r <= 1'b0;
         rp_r       <= {PW{1'b0}};
         wp_r       <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
      end else begin
         if (issue_s) begin
            fpc_r <= fpc_r + STEP;
            ipc_r <= fpc_r;
         end
         inflight_r <= issue_s;
         if (push_s) begin
            wp_r <= wp_r + PW'(1);
         end
         if (pop_s) begin
            rp_r <= rp_r + PW'(1);
         end
         count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // Capture the returning RAM word together with the address it came from
   always_ff @(posedge clk) begin
      if (push_s) begin
         instr_mem_r[wp_r] <= ram_data;
         pc_mem_r[wp_r]    <= ipc_r;
      end
   end

   // Output mapping: strobe follows the issue decision, head entry is read
   // straight from the buffer at rp
   always_comb begin
      ram_load    = issue_s;
      ram_addr    = fpc_r;
      instr_valid = (count_r != {CW{1'b0}});
      instr       = instr_mem_r[rp_r];
      instr_pc    = pc_mem_r[rp_r];
      level       = count_r;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Scoreboard bench for fetch_queue. The main process drives directed stimulus
// and pushes the hand-computed {instr, pc} pairs it expects the CPU side to
// receive; an independent monitor pops and compares on every accepted
// handshake. The RAM model returns addr + 100 one cycle after each strobe.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ram_addr;
   logic        ram_load;
   logic [31:0] ram_data = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic [2:0]  level;

   exp_t sb[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   fetch_queue #(
      .DEPTH(4),
      .RESET_PC(32'h0),
      .ADDR_STEP(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ram_addr(ram_addr),
      .ram_load(ram_load),
      .ram_data(ram_data),
      .redirect_valid(redirect_valid),
      .redirect_addr(redirect_addr),
      .instr_valid(instr_valid),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_ready(instr_ready),
      .level(level)
   );

   // RAM model: word at address a holds a + 100, one-cycle read latency
   always @(posedge clk) begin
      if (ram_load === 1'b1) ram_data <= ram_addr + 32'd100;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every accepted head entry against the scoreboard
   always @(negedge clk) begin
      if (instr_valid === 1'b1 && instr_ready === 1'b1 && sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("pop_pc", instr_pc, mon_e.pc);
         check("pop_instr", instr, mon_e.ins);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_n(input logic [31:0] base, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc  = base + 32'(i);
         e.ins = base + 32'(i) + 32'd100;
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 60) begin
         step();
         k++;
      end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_addr  = 32'h0;
      instr_ready    = 1'b0;

      // ---- reset state ----
      step();
      step();
      @(negedge clk);
      check("rst_ram_load", 32'(ram_load), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_ram_addr", ram_addr, 32'h0);

      // ---- stream with instr_ready held ----
      step();
      reset       = 1'b0;
      instr_ready = 1'b1;
      expect_n(32'h0, 8);
      @(negedge clk);
      check("c0_valid", 32'(instr_valid), 32'd0);
      check("c0_ram_load", 32'(ram_load), 32'd1);
      check("c0_ram_addr", ram_addr, 32'h0);
      step();
      @(negedge clk);
      check("c1_valid", 32'(instr_valid), 32'd0);
      step();
      @(negedge clk);
      check("c2_valid", 32'(instr_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         step();
         @(negedge clk);
         check("stream_nogap", 32'(instr_valid), 32'd1);
         check("stream_level", 32'(level), 32'd1);
      end
      drain("stream_drained");

      // ---- reset mid-operation with level 3 and a read in flight ----
      instr_ready = 1'b0;
      step();
      step();
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      check("pre_rst_level", 32'(level), 32'd3);
      check("rst_blocks_load", 32'(ram_load), 32'd0);
      step();
      @(negedge clk);
      check("midrst_valid", 32'(instr_valid), 32'd0);
      check("midrst_level", 32'(level), 32'd0);
      check("midrst_ram_addr", ram_addr, 32'h0);

      // ---- backpressure: instr_ready low for 10 cycles ----
      step();
      reset = 1'b0;
      expect_n(32'h0, 12);
      @(negedge clk);
      check("bp_c0_load", 32'(ram_load), 32'd1);
      for (int c = 1; c < 10; c++) begin
         step();
         @(negedge clk);
         if (c == 2) check("bp_level_c2", 32'(level), 32'd1);
         if (c == 4) check("bp_level_c4", 32'(level), 32'd3);
         if (c >= 5) begin
            check("bp_full_level", 32'(level), 32'd4);
            check("bp_full_noload", 32'(ram_load), 32'd0);
         end
      end
      step();
      instr_ready = 1'b1;
      @(negedge clk);
      // steady push+pop at level 3
      for (int c = 0; c < 6; c++) begin
         step();
         @(negedge clk);
         check("steady_level3", 32'(level), 32'd3);
      end
      drain("bp_drained");

      // ---- redirect mid-stream with an entry in flight ----
      redirect_valid = 1'b1;
      redirect_addr  = 32'h40;
      instr_ready    = 1'b0;
      sb.delete();
      expect_n(32'h40, 6);
      @(negedge clk);
      check("redir_noload", 32'(ram_load), 32'd0);
      step();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      @(negedge clk);
      check("redir_level", 32'(level), 32'd0);
      check("redir_valid", 32'(instr_valid), 32'd0);
      check("redir_issue", 32'(ram_load), 32'd1);
      check("redir_addr", ram_addr, 32'h40);
      step();
      @(negedge clk);
      check("redir_c2_valid", 32'(instr_valid), 32'd0);
      step();
      @(negedge clk);
      check("redir_c3_valid", 32'(instr_valid), 32'd1);
      drain("redir_drained");

      // ---- back-to-back redirects ----
      redirect_valid = 1'b1;
      redirect_addr  = 32'h100;
      instr_ready    = 1'b0;
      step();
      redirect_addr  = 32'h200;
      step();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      sb.delete();
      expect_n(32'h200, 3);
      @(negedge clk);
      check("b2b_addr", ram_addr, 32'h200);
      check("b2b_load", 32'(ram_load), 32'd1);
      drain("b2b_drained");

      // ---- address wrap-around and pointer wrap ----
      redirect_valid = 1'b1;
      redirect_addr  = 32'hFFFF_FFFE;
      instr_ready    = 1'b0;
      step();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      sb.delete();
      expect_n(32'hFFFF_FFFE, 6);
      @(negedge clk);
      check("wrap_addr", ram_addr, 32'hFFFF_FFFE);
      drain("wrap_drained");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
